// File: rtl/spi_master_fifo_x.sv
// SPI master with TX/RX word FIFOs, runtime CPOL/CPHA, programmable SCLK divider and burst chip-select.
// Latency: a word keeps cs_n low for CLK_DIV*(2*DATA_WIDTH+2) cycles, and the RX word is pushed on its last cycle.
// Backpressure: tx_ready = !tx_full. When the RX FIFO is full, a received word is dropped and rx_ovf is set.

module spi_master_fifo_x_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    // Generic first-word-fall-through FIFO of depth 2**AW.
    // Latency: a pushed word is visible on pop_dat on the next cycle.
    // Backpressure: a push while full and a pop while empty are ignored; both are evaluated against this cycle's level.
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The level can reach DEPTH, but never goes past it, so its MSB alone means full.
    assign full    = level[AW];
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module spi_master_fifo_x #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int CS_IDLE    = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  enable,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  burst_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [ADDR_WIDTH:0]   tx_level,
    output logic [ADDR_WIDTH:0]   rx_level,
    output logic                  rx_ovf,
    input  logic                  rx_ovf_clr,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);
    typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TRAIL, ST_GAP} state_t;

    localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int HW      = $clog2(2 * DATA_WIDTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_IDLE - 1);
    localparam logic [HW-1:0] HP_LAST  = HW'(2 * DATA_WIDTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [HW-1:0]         hp;
    logic                  cpol_l;
    logic                  cpha_l;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  sclk_r;
    logic                  mosi_r;
    logic                  cs_n_r;
    logic                  ovf_r;

    logic                  tx_pop;
    logic                  word_load;
    logic                  rx_push;
    logic                  cnt_clr;
    logic                  hp_clr;
    logic                  hp_inc;
    logic                  edge_lead;
    logic                  edge_trail;
    logic                  cs_rel;
    logic                  phase_last;
    logic                  do_sample;
    logic                  do_shift;

    logic                  tx_empty;
    logic                  tx_full;
    logic                  rx_empty;
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] tx_head;

    spi_master_fifo_x_fifo #(.W(DATA_WIDTH), .AW(ADDR_WIDTH)) u_tx_fifo (
        .clk      (Clk),
        .rst      (Rst),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (tx_pop),
        .pop_dat  (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
    );

    spi_master_fifo_x_fifo #(.W(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rx_fifo (
        .clk      (Clk),
        .rst      (Rst),
        .push     (rx_push),
        .push_dat (rx_sh),
        .pop      (rx_ready),
        .pop_dat  (rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
    );

    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign rx_ovf     = ovf_r;
    assign busy       = (state != ST_IDLE);
    assign sclk       = sclk_r;
    assign mosi       = mosi_r;
    assign cs_n       = cs_n_r;
    assign phase_last = (cnt == DIV_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Edge numbering: edge 1 comes at LEAD->SHIFT, and every later SHIFT half-period boundary adds one more.
    // Odd-numbered edges are leading edges, even-numbered edges are trailing edges.
    always_comb begin
        state_nxt  = state;
        tx_pop     = 1'b0;
        word_load  = 1'b0;
        rx_push    = 1'b0;
        cnt_clr    = 1'b0;
        hp_clr     = 1'b0;
        hp_inc     = 1'b0;
        edge_lead  = 1'b0;
        edge_trail = 1'b0;
        cs_rel     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (enable && !tx_empty) begin
                    tx_pop    = 1'b1;
                    word_load = 1'b1;
                    state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (phase_last) begin
                    cnt_clr   = 1'b1;
                    hp_clr    = 1'b1;
                    edge_lead = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (phase_last) begin
                    cnt_clr = 1'b1;
                    if (hp == HP_LAST) begin
                        state_nxt = ST_TRAIL;
                    end else begin
                        hp_inc     = 1'b1;
                        edge_lead  = hp[0];
                        edge_trail = !hp[0];
                    end
                end
            end
            ST_TRAIL: begin
                if (phase_last) begin
                    cnt_clr = 1'b1;
                    rx_push = 1'b1;
                    if (burst_en && enable && !tx_empty) begin
                        tx_pop    = 1'b1;
                        word_load = 1'b1;
                        state_nxt = ST_LEAD;
                    end else begin
                        cs_rel    = 1'b1;
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign do_sample = (edge_lead && !cpha_l) || (edge_trail && cpha_l);
    assign do_shift  = (edge_lead && cpha_l) || (edge_trail && !cpha_l);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
            hp  <= '0;
        end else begin
            if (cnt_clr) cnt <= '0;
            else         cnt <= cnt + 1'b1;
            if (hp_clr)      hp <= '0;
            else if (hp_inc) hp <= hp + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            sclk_r <= 1'b0;
            mosi_r <= 1'b0;
            cs_n_r <= 1'b1;
        end else if (word_load) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            cs_n_r <= 1'b0;
            sclk_r <= cpol;
            // With cpha=0 the MSB must already be on mosi before the first edge; with cpha=1 the first edge drives it.
            if (cpha) begin
                tx_sh <= tx_head;
            end else begin
                mosi_r <= tx_head[DATA_WIDTH-1];
                tx_sh  <= tx_head << 1;
            end
        end else begin
            if (state == ST_IDLE)        sclk_r <= cpol;
            if (edge_lead || edge_trail) sclk_r <= ~sclk_r;
            if (do_shift) begin
                mosi_r <= tx_sh[DATA_WIDTH-1];
                tx_sh  <= tx_sh << 1;
            end
            if (do_sample) rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
            if (cs_rel)    cs_n_r <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst)                      ovf_r <= 1'b0;
        else if (rx_push && rx_full)  ovf_r <= 1'b1;
        else if (rx_ovf_clr)          ovf_r <= 1'b0;
    end
endmodule

// File: tb/tb_spi_master_fifo_x.sv
`timescale 1ns/1ps
// Directed and randomized bench for spi_master_fifo_x, using a behavioural SPI slave and word-order scoreboards.
module tb_spi_master_fifo_x;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          enable;
    logic          cpol;
    logic          cpha;
    logic          burst_en;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic          rx_ovf;
    logic          rx_ovf_clr;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    always #5 Clk = ~Clk;

    spi_master_fifo_x #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(2), .CS_IDLE(4)) dut (
        .Clk(Clk), .Rst(Rst), .enable(enable), .cpol(cpol), .cpha(cpha), .burst_en(burst_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .rx_ovf(rx_ovf), .rx_ovf_clr(rx_ovf_clr),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    int        n_cmp = 0;
    int        n_bad = 0;
    logic [7:0] s_words [0:63];   // words the slave returns, in order
    logic [7:0] tx_w    [0:63];   // words the master is expected to send, in order
    logic [7:0] s_got   [0:63];
    int        s_got_n, s_cur, s_edges;
    logic [7:0] s_out, s_in;
    logic      s_prev_cs, s_prev_sclk, s_start_sclk;
    int        low_run [0:63];
    int        hi_run  [0:63];
    int        n_low, n_hi, low_cnt, hi_cnt;
    logic      mon_clr;

    task automatic s_prep();
        s_out = s_words[s_cur[5:0]];
        s_in  = '0;
        if (!cpha) begin
            miso  = s_out[7];
            s_out = s_out << 1;
        end
    endtask

    // SPI slave plus cs_n run-length monitor; it acts on the falling Clk edge, half a cycle after the DUT updates.
    always @(negedge Clk) begin
        if (Rst || mon_clr) begin
            s_got_n = 0; s_cur = 0; s_edges = 0; miso = 1'b0;
            n_low = 0; n_hi = 0; low_cnt = 0; hi_cnt = 0;
        end else begin
            if (!cs_n && s_prev_cs) begin
                s_start_sclk = sclk;
                s_edges = 0;
                s_prep();
            end else if (!cs_n && sclk != s_prev_sclk) begin
                s_edges++;
                if (s_edges[0] != cpha) s_in = {s_in[6:0], mosi};
                else begin
                    miso  = s_out[7];
                    s_out = s_out << 1;
                end
                if (s_edges == 2 * DW) begin
                    s_got[s_got_n[5:0]] = s_in;
                    s_got_n++;
                    s_cur++;
                    s_edges = 0;
                    s_prep();
                end
            end
            if (!cs_n) begin
                low_cnt++;
                if (hi_cnt > 0) begin hi_run[n_hi[5:0]] = hi_cnt; n_hi++; hi_cnt = 0; end
            end else begin
                hi_cnt++;
                if (low_cnt > 0) begin low_run[n_low[5:0]] = low_cnt; n_low++; low_cnt = 0; end
            end
        end
        s_prev_cs   = cs_n;
        s_prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge Clk);
        #1 mon_clr = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (!(busy == 1'b0 && tx_level == '0) && k < budget) begin
            cyc(1);
            k++;
        end
        chk(tag, 32'(k >= budget), 0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, rx_valid, 1);
        chk(tag, rx_data, exp);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_words(input string tag, input int n);
        chk({tag, "_cnt"}, s_got_n, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_mosi%0d", tag, i), s_got[i], tx_w[i]);
            pop_chk($sformatf("%s_rx%0d", tag, i), s_words[i]);
        end
        chk({tag, "_rx_empty"}, rx_valid, 0);
    endtask

    initial begin
        int acc;
        int k;
        Rst = 1'b1; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; burst_en = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; rx_ovf_clr = 1'b0; mon_clr = 1'b0;
        cyc(3);
        Rst = 1'b0;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_ovf", rx_ovf, 0);
        chk("rst_tx_ready", tx_ready, 1);

        // All four modes: 0xA5 goes out, and the slave answers 0x3C.
        for (int m = 0; m < 4; m++) begin
            enable = 1'b0;
            cpol = m[1];
            cpha = m[0];
            s_words[0] = 8'h3C;
            tx_w[0] = 8'hA5;
            clr_mon();
            chk($sformatf("m%0d_sclk_idle", m), sclk, cpol);
            enable = 1'b1;
            push(8'hA5);
            wait_idle(500, $sformatf("m%0d_done", m));
            chk($sformatf("m%0d_start_sclk", m), s_start_sclk, cpol);
            chk($sformatf("m%0d_nlow", m), n_low, 1);
            chk($sformatf("m%0d_cs_low", m), low_run[0], 36);
            check_words($sformatf("m%0d", m), 1);
            chk($sformatf("m%0d_sclk_end", m), sclk, cpol);
        end

        // Random data and a random mode for each word; the RX FIFO collects all of them.
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_words[i] = 8'($urandom);
            tx_w[i] = 8'($urandom);
        end
        clr_mon();
        for (int i = 0; i < 6; i++) begin
            cpol = 1'($urandom);
            cpha = 1'($urandom);
            cyc(1);
            push(tx_w[i]);
            wait_idle(500, $sformatf("rnd%0d_done", i));
        end
        chk("rnd_rx_level", rx_level, 6);
        check_words("rnd", 6);

        // Burst mode keeps cs_n low for three back-to-back words; non-burst mode leaves gaps between them.
        for (int b = 1; b >= 0; b--) begin
            enable = 1'b0; cpol = 1'b0; cpha = 1'b0; burst_en = b[0];
            for (int i = 0; i < 3; i++) begin
                s_words[i] = 8'($urandom);
                tx_w[i] = 8'($urandom);
            end
            clr_mon();
            for (int i = 0; i < 3; i++) push(tx_w[i]);
            enable = 1'b1;
            wait_idle(1000, $sformatf("b%0d_done", b));
            if (b == 1) begin
                chk("burst_nlow", n_low, 1);
                chk("burst_cs_low", low_run[0], 108);
            end else begin
                chk("gap_nlow", n_low, 3);
                for (int i = 0; i < 3; i++) chk($sformatf("gap_low%0d", i), low_run[i], 36);
                chk("gap_hi1_ge4", 32'(hi_run[1] >= 4), 1);
                chk("gap_hi2_ge4", 32'(hi_run[2] >= 4), 1);
            end
            check_words($sformatf("b%0d", b), 3);
        end

        // Fill the TX FIFO and try one extra push. Then overflow the RX FIFO and clear the overflow flag.
        enable = 1'b0; burst_en = 1'b0; cpol = 1'b0; cpha = 1'b0;
        for (int i = 0; i < 17; i++) s_words[i] = 8'($urandom);
        clr_mon();
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            push(d);
            if (acc < 16) begin
                tx_w[acc] = d;
                acc++;
            end
        end
        chk("full_tx_level", tx_level, 16);
        chk("full_tx_ready", tx_ready, 0);
        enable = 1'b1;
        wait_idle(2000, "full_done");
        chk("full_shifted", s_got_n, 16);
        chk("full_rx_level", rx_level, 16);
        chk("full_ovf0", rx_ovf, 0);
        tx_w[16] = 8'($urandom);
        push(tx_w[16]);
        wait_idle(500, "ovf_done");
        chk("ovf_shifted", s_got_n, 17);
        chk("ovf_rx_level", rx_level, 16);
        chk("ovf_set", rx_ovf, 1);
        for (int i = 0; i < 17; i++) chk($sformatf("ovf_mosi%0d", i), s_got[i], tx_w[i]);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("ovf_rx%0d", i), s_words[i]);
        chk("ovf_rx_empty", rx_valid, 0);
        chk("ovf_sticky", rx_ovf, 1);
        rx_ovf_clr = 1'b1;
        cyc(1);
        rx_ovf_clr = 1'b0;
        chk("ovf_cleared", rx_ovf, 0);

        // Reset in the middle of SHIFT, with words waiting in both FIFOs.
        enable = 1'b1;
        s_words[0] = 8'($urandom);
        clr_mon();
        push(8'($urandom));
        wait_idle(500, "pre_rst_done");
        chk("pre_rst_rx_level", rx_level, 1);
        enable = 1'b0;
        push(8'($urandom));
        push(8'($urandom));
        enable = 1'b1;
        k = 0;
        while (cs_n !== 1'b0 && k < 100) begin
            cyc(1);
            k++;
        end
        chk("pre_rst_start", 32'(k >= 100), 0);
        cyc(10);
        chk("pre_rst_busy", busy, 1);
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_level", tx_level, 0);
        chk("mid_rst_rx_level", rx_level, 0);
        chk("mid_rst_sclk", sclk, 0);
        s_words[0] = 8'($urandom);
        tx_w[0] = 8'($urandom);
        clr_mon();
        push(tx_w[0]);
        wait_idle(500, "post_rst_done");
        chk("post_rst_cs_low", low_run[0], 36);
        check_words("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
